dec_10b8b_multilane: RTL

- Parametrised successor of the single-symbol 10b/8b decoder. Decodes LANES 10-bit symbols per beat in one registered stage.
- Tracks running disparity (RD) internally and chains it across lanes within a beat and across beats, so the caller no longer supplies rdisp_in.
- Adds a valid handshake, K28.5 comma flags, RD preload and a saturating error counter.
- Sits between the deserialiser/aligner and the IEEE1149.10 packet layer.

---
 rtl/dec_10b8b_multilane.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dec_10b8b_multilane.sv
// Multi-lane 10b/8b decoder with internally tracked running disparity.
// Decodes LANES symbols per beat in one registered stage; lane 0 is the
// earliest symbol, and RD chains lane to lane and beat to beat.
module dec_10b8b_multilane #(
    parameter int unsigned LANES     = 2,
    parameter logic        INIT_RD   = 1'b0,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [10*LANES-1:0]    data_in,
    input  logic                   rd_load,
    input  logic                   rd_load_val,
    input  logic                   err_cnt_clr,
    output logic                   out_valid,
    output logic [8*LANES-1:0]     data_out,
    output logic [LANES-1:0]       k_out,
    output logic [LANES-1:0]       comma_det,
    output logic [LANES-1:0]       code_err,
    output logic [LANES-1:0]       disp_err,
    output logic                   rd_out,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int unsigned SUM_W = ERR_CNT_W + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = {{4{1'b0}}, {ERR_CNT_W{1'b1}}};

    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic       comma;
        logic       cerr;
        logic       derr;
        logic       rd;
    } lane_res_t;

    function automatic logic [3:0] popcnt10(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // 6b sub-block (abcdei) -> {known, EDCBA}; K28 sub-blocks are handled separately
    function automatic logic [5:0] map6(input logic [5:0] s);
        logic [5:0] r;
        case (s)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b110101, 6'b001010: r = {1'b1, 5'd4};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b111000, 6'b000111: r = {1'b1, 5'd7};
            6'b111001, 6'b000110: r = {1'b1, 5'd8};
            6'b100101:            r = {1'b1, 5'd9};
            6'b010101:            r = {1'b1, 5'd10};
            6'b110100:            r = {1'b1, 5'd11};
            6'b001101:            r = {1'b1, 5'd12};
            6'b101100:            r = {1'b1, 5'd13};
            6'b011100:            r = {1'b1, 5'd14};
            6'b010111, 6'b101000: r = {1'b1, 5'd15};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b100011:            r = {1'b1, 5'd17};
            6'b010011:            r = {1'b1, 5'd18};
            6'b110010:            r = {1'b1, 5'd19};
            6'b001011:            r = {1'b1, 5'd20};
            6'b101010:            r = {1'b1, 5'd21};
            6'b011010:            r = {1'b1, 5'd22};
            6'b111010, 6'b000101: r = {1'b1, 5'd23};
            6'b110011, 6'b001100: r = {1'b1, 5'd24};
            6'b100110:            r = {1'b1, 5'd25};
            6'b010110:            r = {1'b1, 5'd26};
            6'b110110, 6'b001001: r = {1'b1, 5'd27};
            6'b001110:            r = {1'b1, 5'd28};
            6'b101110, 6'b010001: r = {1'b1, 5'd29};
            6'b011110, 6'b100001: r = {1'b1, 5'd30};
            6'b101011, 6'b010100: r = {1'b1, 5'd31};
            default:              r = '0;
        endcase
        return r;
    endfunction

    // 4b sub-block (fghj) -> HGF, ignoring which RD column it came from
    function automatic logic [2:0] map4(input logic [3:0] f);
        logic [2:0] y;
        case (f)
            4'b1011, 4'b0100:                   y = 3'd0;
            4'b1001:                            y = 3'd1;
            4'b0101:                            y = 3'd2;
            4'b1100, 4'b0011:                   y = 3'd3;
            4'b1101, 4'b0010:                   y = 3'd4;
            4'b1010:                            y = 3'd5;
            4'b0110:                            y = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
            default:                            y = 3'd0;
        endcase
        return y;
    endfunction

    // A symbol is legal if it belongs to either RD column: the 6b block fixes
    // which column(s) are possible and hence the RD seen by the 4b block.
    function automatic lane_res_t decode_sym(input logic [9:0] sym, input logic rd_in);
        lane_res_t  r;
        logic [5:0] sb6;
        logic [3:0] sb4;
        logic [3:0] k4;
        logic [3:0] ones;
        logic [3:0] ones6;
        logic [5:0] m6;
        logic [4:0] x;
        logic [2:0] y;
        logic ok6, k28m, k28p, rdm_ok, rdp_ok, a7m, a7p, in_m, in_p, k28_set;
        logic is_data, is_kx7, is_k28, valid;

        r     = '0;
        sb6   = sym[9:4];
        sb4   = sym[3:0];
        ones  = popcnt10(sym);
        ones6 = popcnt10({4'b0000, sb6});
        m6    = map6(sb6);
        ok6   = m6[5];
        x     = m6[4:0];
        k28m  = (sb6 == 6'b001111);
        k28p  = (sb6 == 6'b110000);
        k4    = k28p ? ~sb4 : sb4;

        // RD at the 4b boundary that the 6b block allows (D.7 is column-specific)
        rdm_ok = ok6 && ((ones6 == 4'd2) || ((ones6 == 4'd3) && (sb6 != 6'b000111)));
        rdp_ok = ok6 && ((ones6 == 4'd4) || ((ones6 == 4'd3) && (sb6 != 6'b111000)));
        a7m    = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        a7p    = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);

        case (sb4)
            4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110: in_m = 1'b1;
            4'b1110: in_m = !a7m;
            4'b0111: in_m = a7m;
            default: in_m = 1'b0;
        endcase
        case (sb4)
            4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110: in_p = 1'b1;
            4'b0001: in_p = !a7p;
            4'b1000: in_p = a7p;
            default: in_p = 1'b0;
        endcase
        case (k4)
            4'b0100, 4'b1001, 4'b0101, 4'b0011,
            4'b0010, 4'b1010, 4'b0110, 4'b1000: k28_set = 1'b1;
            default:                            k28_set = 1'b0;
        endcase

        is_data = (rdm_ok && in_m) || (rdp_ok && in_p);
        is_kx7  = ok6 && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)) &&
                  (((ones6 == 4'd4) && (sb4 == 4'b1000)) || ((ones6 == 4'd2) && (sb4 == 4'b0111)));
        is_k28  = (k28m || k28p) && k28_set;
        valid   = (is_data || is_kx7 || is_k28) && (ones >= 4'd4) && (ones <= 4'd6);

        if (!valid) begin
            r.cerr = 1'b1;
            r.rd   = rd_in;
        end else begin
            y       = is_k28 ? map4(k4) : map4(sb4);
            r.data  = {y, (is_k28 ? 5'd28 : x)};
            r.k     = is_kx7 || is_k28;
            r.comma = is_k28 && (y == 3'd5);
            if (ones == 4'd6) begin
                r.derr = rd_in;
                r.rd   = 1'b1;
            end else if (ones == 4'd4) begin
                r.derr = !rd_in;
                r.rd   = 1'b0;
            end else begin
                // neutral overall but with an imbalanced 6b block: column is set by the 6b block
                r.derr = (ones6 != 4'd3) && (rd_in != (ones6 == 4'd2));
                r.rd   = rd_in;
            end
        end
        return r;
    endfunction

    logic                   rd_q;
    logic                   rd_last;
    logic [8*LANES-1:0]     nxt_data;
    logic [LANES-1:0]       nxt_k;
    logic [LANES-1:0]       nxt_comma;
    logic [LANES-1:0]       nxt_cerr;
    logic [LANES-1:0]       nxt_derr;
    logic [3:0]             beat_errs;
    logic [SUM_W-1:0]       cnt_sum;
    logic [ERR_CNT_W-1:0]   err_nxt;

    assign rd_out = rd_q;

    // Decode all lanes with RD rippling lane to lane, and form the next error count
    always_comb begin
        lane_res_t res;
        logic      rd_c;
        rd_c      = rd_load ? rd_load_val : rd_q;
        nxt_data  = '0;
        nxt_k     = '0;
        nxt_comma = '0;
        nxt_cerr  = '0;
        nxt_derr  = '0;
        beat_errs = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            res                 = decode_sym(data_in[10*i +: 10], rd_c);
            nxt_data[8*i +: 8]  = res.data;
            nxt_k[i]            = res.k;
            nxt_comma[i]        = res.comma;
            nxt_cerr[i]         = res.cerr;
            nxt_derr[i]         = res.derr;
            beat_errs           = beat_errs + {3'b000, res.cerr | res.derr};
            rd_c                = res.rd;
        end
        rd_last = rd_c;

        // clear and accumulate share one adder so a clearing beat still counts its errors
        cnt_sum = (err_cnt_clr ? {SUM_W{1'b0}} : {4'b0000, err_cnt}) +
                  {{ERR_CNT_W{1'b0}}, (in_valid ? beat_errs : 4'd0)};
        err_nxt = (cnt_sum > CNT_MAX) ? CNT_MAX[ERR_CNT_W-1:0] : cnt_sum[ERR_CNT_W-1:0];
    end

    // Output register, RD state and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            k_out     <= '0;
            comma_det <= '0;
            code_err  <= '0;
            disp_err  <= '0;
            rd_q      <= INIT_RD;
            err_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= nxt_data;
                k_out     <= nxt_k;
                comma_det <= nxt_comma;
                code_err  <= nxt_cerr;
                disp_err  <= nxt_derr;
                rd_q      <= rd_last;
            end else if (rd_load) begin
                rd_q      <= rd_load_val;
            end
            err_cnt <= err_nxt;
        end
    end

endmodule
